// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the APB round-robin arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_e;

  localparam int APB_DATA_WIDTH = 32;

  // Width of the wait-state counter; at least one bit even when the timeout is disabled.
  function automatic int cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Requester-side and completer-side APB signals of the shared bus.
interface apb_rr_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32
);
  logic [NUM_REQ-1:0]                req_psel_i;
  logic [NUM_REQ-1:0]                req_pwrite_i;
  logic [NUM_REQ*AW-1:0]             req_paddr_i;
  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_pwdata_i;
  logic [APB_DATA_WIDTH-1:0]         req_prdata_o;
  logic [NUM_REQ-1:0]                req_pready_o;
  logic [NUM_REQ-1:0]                req_pslverr_o;
  logic                              PSEL;
  logic                              PENABLE;
  logic                              PWRITE;
  logic [AW-1:0]                     PADDR;
  logic [APB_DATA_WIDTH-1:0]         PWDATA;
  logic [APB_DATA_WIDTH-1:0]         PRDATA;
  logic                              PREADY;
  logic                              PSLVERR;

  modport slave (
    input  req_psel_i, req_pwrite_i, req_paddr_i, req_pwdata_i, PRDATA, PREADY, PSLVERR,
    output req_prdata_o, req_pready_o, req_pslverr_o, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport master (
    output req_psel_i, req_pwrite_i, req_paddr_i, req_pwdata_i, PRDATA, PREADY, PSLVERR,
    input  req_prdata_o, req_pready_o, req_pslverr_o, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_rr_arbiter_picker.sv
// Rotating-priority encoder: first set request after the last winner, wrapping mod N.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          i_req,
  input  logic [idx_w(N)-1:0]   i_last,
  output logic                  o_vld,
  output logic [idx_w(N)-1:0]   o_idx
);
  localparam int IW = idx_w(N);

  logic [IW-1:0] w_cand;

  // Walk from the farthest offset down so the nearest requester after i_last wins.
  always_comb begin
    o_vld  = |i_req;
    o_idx  = '0;
    w_cand = '0;
    for (int off = N; off >= 1; off--) begin
      w_cand = IW'((int'(i_last) + off) % N);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end
endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB completer among NUM_REQ requesters, with wait-state timeout.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  apb_rr_arbiter_if.slave           bus,
  output logic [idx_w(NUM_REQ)-1:0] grant_o,
  output logic                      timeout_o
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e         r_state;
  logic [IW-1:0]      r_grant, r_last, w_idx;
  logic               w_vld;
  logic [CW-1:0]      r_cnt;
  logic               r_psel, r_penable, r_pwrite;
  logic [AW-1:0]      r_paddr;
  logic [DW-1:0]      r_pwdata;
  logic               w_to_hit, w_done;
  logic [NUM_REQ-1:0] w_pready, w_pslverr;

  apb_rr_picker #(.N(NUM_REQ)) u_picker (
    .i_req  (bus.req_psel_i),
    .i_last (r_last),
    .o_vld  (w_vld),
    .o_idx  (w_idx)
  );

  assign w_to_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST) && !bus.PREADY;
  assign w_done   = bus.PREADY | w_to_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= IW'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_vld) begin
          r_grant  <= w_idx;
          r_last   <= w_idx;
          r_pwrite <= bus.req_pwrite_i[w_idx];
          r_paddr  <= bus.req_paddr_i[int'(w_idx)*AW +: AW];
          r_pwdata <= bus.req_pwdata_i[int'(w_idx)*DW +: DW];
          r_psel   <= 1'b1;
          r_state  <= SETUP;
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // Saturate so a disabled or long timeout can never wrap back into the compare.
          if (!bus.PREADY && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_pready  = '0;
    w_pslverr = '0;
    if (r_state == ACCESS && w_done) begin
      w_pready[r_grant]  = 1'b1;
      w_pslverr[r_grant] = w_to_hit | bus.PSLVERR;
    end
  end

  assign timeout_o         = (r_state == ACCESS) && w_to_hit;
  assign grant_o           = r_grant;
  assign bus.req_pready_o  = w_pready;
  assign bus.req_pslverr_o = w_pslverr;
  assign bus.req_prdata_o  = bus.PRDATA;
  assign bus.PSEL          = r_psel;
  assign bus.PENABLE       = r_penable;
  assign bus.PWRITE        = r_pwrite;
  assign bus.PADDR         = r_paddr;
  assign bus.PWDATA        = r_pwdata;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench: requester queues drive the arbiter, a completer model answers, completions are checked in order.
module tb_apb_rr_arbiter;
  import apb_arb_pkg::*;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int TO = 8;

  typedef struct packed {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct packed {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    bit          to;
    int          acc_len;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] grant_o;
  logic       timeout_o;

  apb_rr_arbiter_if #(.NUM_REQ(NR), .AW(AW)) bus ();

  apb_rr_arbiter #(.NUM_REQ(NR), .APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .bus       (bus),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  xfer_t rq[NR][$];
  exp_t  sb[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    cfg_wait = 0;   // ACCESS wait cycles before PREADY; negative means never ready
  bit    cfg_err = 1'b0;

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a == 32'h100) return 32'h1111;
    if (a == 32'h200) return 32'h2222;
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push(input int i, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    xfer_t x;
    exp_t  e;
    x.wr = wr; x.addr = addr; x.wdata = wdata;
    rq[i].push_back(x);
    e.idx = i; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.rdata   = exp_rdata(addr);
    e.to      = (cfg_wait < 0) || (cfg_wait >= TO);
    e.err     = e.to | cfg_err;
    e.acc_len = e.to ? TO : cfg_wait + 1;
    sb.push_back(e);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk_i);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk_i);
    #2;
  endtask

  // Completer model: answers each ACCESS cycle just after the falling edge.
  initial begin
    int acc = 0;
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    forever begin
      @(negedge clk_i);
      if (bus.PSEL && bus.PENABLE) begin
        bus.PREADY  = (cfg_wait >= 0) && (acc >= cfg_wait);
        bus.PSLVERR = cfg_err;
        bus.PRDATA  = exp_rdata(bus.PADDR);
        acc++;
      end else begin
        acc = 0;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
      end
    end
  end

  // Monitor + requester drivers.
  initial begin
    bit   prev_done = 1'b0;
    int   n_set = 0;
    int   n_acc = 0;
    exp_t e;
    bus.req_psel_i = '0; bus.req_pwrite_i = '0; bus.req_paddr_i = '0; bus.req_pwdata_i = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (prev_done) chk("idle_gap_psel", 32'(bus.PSEL), 32'd0);
      prev_done = 1'b0;
      if (!bus.PSEL) begin n_set = 0; n_acc = 0; end
      else if (!bus.PENABLE) n_set++;
      else n_acc++;
      if (|bus.req_pready_o) begin
        if (sb.size() == 0) chk("unexpected_pready", 32'(bus.req_pready_o), 32'd0);
        else begin
          e = sb.pop_front();
          chk("grant",     32'(grant_o),            32'(e.idx));
          chk("pready",    32'(bus.req_pready_o),   32'd1 << e.idx);
          chk("pslverr",   32'(bus.req_pslverr_o),  32'(e.err) << e.idx);
          chk("timeout",   32'(timeout_o),          32'(e.to));
          chk("pwrite",    32'(bus.PWRITE),         32'(e.wr));
          chk("paddr",     bus.PADDR,               e.addr);
          if (e.wr) chk("pwdata", bus.PWDATA, e.wdata);
          if (!e.wr && !e.to) chk("prdata", bus.req_prdata_o, e.rdata);
          chk("access_len", 32'(n_acc), 32'(e.acc_len));
          chk("setup_len",  32'(n_set), 32'd1);
        end
        for (int i = 0; i < NR; i++)
          if (bus.req_pready_o[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        prev_done = 1'b1;
      end else if (timeout_o) chk("stray_timeout", 32'(timeout_o), 32'd0);
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0) begin
          bus.req_psel_i[i]            = 1'b1;
          bus.req_pwrite_i[i]          = rq[i][0].wr;
          bus.req_paddr_i[i*AW +: AW]  = rq[i][0].addr;
          bus.req_pwdata_i[i*32 +: 32] = rq[i][0].wdata;
        end else bus.req_psel_i[i] = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit    seen;
    xfer_t x;
    #22;
    chk("rst_psel",    32'(bus.PSEL),          32'd0);
    chk("rst_penable", 32'(bus.PENABLE),       32'd0);
    chk("rst_pwrite",  32'(bus.PWRITE),        32'd0);
    chk("rst_paddr",   bus.PADDR,              32'd0);
    chk("rst_pwdata",  bus.PWDATA,             32'd0);
    chk("rst_grant",   32'(grant_o),           32'd0);
    chk("rst_pready",  32'(bus.req_pready_o),  32'd0);
    chk("rst_pslverr", 32'(bus.req_pslverr_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o),         32'd0);
    @(posedge clk_i); #2; rst_ni = 1'b1;

    // Simultaneous reads from 0 and 1: alternate 0,1,0,1.
    cfg_wait = 0; cfg_err = 1'b0;
    @(posedge clk_i); #2;
    push(0, 1'b0, 32'h100, 32'h0); push(1, 1'b0, 32'h200, 32'h0);
    push(0, 1'b0, 32'h100, 32'h0); push(1, 1'b0, 32'h200, 32'h0);
    drain(100);

    // Single write with cycle-exact phase checks.
    @(posedge clk_i); #2;
    push(0, 1'b1, 32'h1A10_0004, 32'hDEADBEEF);
    @(posedge clk_i);
    @(negedge clk_i); #2;
    chk("sw_setup_psel",    32'(bus.PSEL),    32'd1);
    chk("sw_setup_penable", 32'(bus.PENABLE), 32'd0);
    @(negedge clk_i); #2;
    chk("sw_access_penable", 32'(bus.PENABLE),      32'd1);
    chk("sw_access_pready",  32'(bus.req_pready_o), 32'd1);
    chk("sw_access_pwdata",  bus.PWDATA,            32'hDEADBEEF);
    drain(20);

    // Five wait states then an error response.
    cfg_wait = 5; cfg_err = 1'b1;
    push(1, 1'b0, 32'h3000, 32'h0);
    drain(40);

    // Hung completer: killed after TO ACCESS cycles.
    cfg_wait = -1; cfg_err = 1'b0;
    push(2, 1'b1, 32'h4000, 32'hCAFE0002);
    drain(40);

    // Three-way fairness with all requesters held.
    cfg_wait = 0;
    @(posedge clk_i); #2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        push(i, r[0], 32'h10 * (i + 1) + 32'(r), 32'hB000_0000 + 32'(i));
    drain(100);

    // Reset during ACCESS of requester 0; afterwards 0 must still beat 1.
    cfg_wait = -1;
    x.wr = 1'b1; x.addr = 32'h5000; x.wdata = 32'h0BAD_0BAD;
    rq[0].push_back(x);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i); #2;
      seen = bus.PSEL && bus.PENABLE;
    end
    chk("rst_reach_access", 32'(seen), 32'd1);
    #1; rst_ni = 1'b0; #1;
    chk("midrst_psel",    32'(bus.PSEL),         32'd0);
    chk("midrst_penable", 32'(bus.PENABLE),      32'd0);
    chk("midrst_pready",  32'(bus.req_pready_o), 32'd0);
    chk("midrst_grant",   32'(grant_o),          32'd0);
    rq[0].delete();
    repeat (2) @(posedge clk_i);
    #3; rst_ni = 1'b1;
    cfg_wait = 0;
    @(posedge clk_i); #2;
    push(0, 1'b0, 32'h6000, 32'h0); push(1, 1'b0, 32'h7000, 32'h0);
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
